// File: rtl/vec_lsu_pkg.sv
// Shared types and defaults for the strided vector load/store unit.
//   sew_e       : element width encoding carried on cmd_sew
//   lsu_state_e : command sequencer states
//   sew_bytes() : bytes per element for a given SEW (0 for the illegal code)
package vec_lsu_pkg;

  localparam int VLEN_DEF   = 256;
  localparam int MAX_VL_DEF = VLEN_DEF / 8;

  typedef enum logic [1:0] {
    SEW_8   = 2'b00,
    SEW_16  = 2'b01,
    SEW_32  = 2'b10,
    SEW_ILL = 2'b11
  } sew_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_NEXT,
    S_WB,
    S_DONE
  } lsu_state_e;

  function automatic logic [2:0] sew_bytes(sew_e sew);
    case (sew)
      SEW_8:   return 3'd1;
      SEW_16:  return 3'd2;
      SEW_32:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vec_lsu_lane_align.sv
// Combinational byte-lane steering between one vector element and a 32-bit bus word.
//   sew        in  element width
//   lane       in  byte offset of the element inside the word (elem_addr[1:0])
//   rdata      in  bus read word
//   st_elem    in  store element, right-justified
//   ld_elem    out load element extracted from lane, zero-extended
//   st_wdata   out store element shifted up to its byte lane
//   st_wstrb   out byte enables covering the element
//   misaligned out element would straddle the word boundary
module vec_lsu_lane_align
  import vec_lsu_pkg::*;
(
  input  sew_e        sew,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] st_elem,
  output logic [31:0] ld_elem,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  output logic        misaligned
);

  logic [2:0]  nb;
  logic [4:0]  lane_sh;
  logic [31:0] elem_mask;
  logic [3:0]  strb_base;

  always_comb begin
    nb      = sew_bytes(sew);
    lane_sh = {lane, 3'b000};
    case (sew)
      SEW_8:   begin elem_mask = 32'h0000_00FF; strb_base = 4'b0001; end
      SEW_16:  begin elem_mask = 32'h0000_FFFF; strb_base = 4'b0011; end
      SEW_32:  begin elem_mask = 32'hFFFF_FFFF; strb_base = 4'b1111; end
      default: begin elem_mask = 32'h0;         strb_base = 4'b0000; end
    endcase
    misaligned = ({1'b0, lane} + nb) > 3'd4;
    ld_elem    = (rdata >> lane_sh) & elem_mask;
    st_wdata   = (st_elem & elem_mask) << lane_sh;
    st_wstrb   = strb_base << lane;
  end

endmodule

// File: rtl/vec_lsu_strided.sv
// Strided vector load/store initiator (vlse.v / vsse.v), one element per bus transaction.
// Accepts one command in IDLE, walks vl elements at base + i*stride, and for loads writes
// the assembled register back in a single vreg_we pulse; done/err report the outcome.
// Ports:
//   clk, reset                          single clock, synchronous active-high reset
//   cmd_valid/cmd_ready                 command handshake (ready only while idle)
//   cmd_store/base/stride/vl/sew/vreg   command fields
//   cmd_vdata                           store source or prior register value for loads
//   cmd_vm, cmd_mask                    element masking (cmd_mask only with VEC_LSU_MASK_EN)
//   mem_valid/ready/addr/wdata/wstrb/rdata  word-addressed memory port
//   vreg_we/waddr/wdata                 load writeback
//   done, err                           completion pulse and abort flag (err held until next accept)
// Configuration macro: VEC_LSU_MASK_EN enables per-element masking via cmd_vm/cmd_mask.
module vec_lsu_strided
  import vec_lsu_pkg::*;
#(
  parameter  int VLEN   = VLEN_DEF,
  parameter  int MAX_VL = VLEN / 8,
  localparam int VLW    = $clog2(MAX_VL) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_store,
  input  logic [31:0]       cmd_base,
  input  logic [31:0]       cmd_stride,
  input  logic [VLW-1:0]    cmd_vl,
  input  logic [1:0]        cmd_sew,
  input  logic [4:0]        cmd_vreg,
  input  logic [VLEN-1:0]   cmd_vdata,
  input  logic              cmd_vm,
`ifdef VEC_LSU_MASK_EN
  input  logic [MAX_VL-1:0] cmd_mask,
`endif
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  output logic              vreg_we,
  output logic [4:0]        vreg_waddr,
  output logic [VLEN-1:0]   vreg_wdata,
  output logic              done,
  output logic              err
);

  localparam int BW = $clog2(VLEN);

  lsu_state_e       state_q, state_d;
  logic             store_q;
  logic [31:0]      ea_q;
  logic [31:0]      stride_q;
  logic [VLW-1:0]   vl_q;
  logic [VLW-1:0]   i_q;
  sew_e             sew_q;
  logic [4:0]       vreg_q;
  logic [VLEN-1:0]  buf_q;
  logic             err_q;

  logic             accept;
  logic             elem_active;
  logic             last_elem;
  logic             cfg_bad;
  logic [VLW-1:0]   vl_limit;
  logic [BW-1:0]    boff;
  logic             ld_fire;
  logic [31:0]      st_elem;
  logic [31:0]      ld_elem;
  logic [31:0]      st_wdata;
  logic [3:0]       st_wstrb;
  logic             misaligned;

`ifdef VEC_LSU_MASK_EN
  logic              vm_q;
  logic [MAX_VL-1:0] mask_q;
  assign elem_active = vm_q || mask_q[i_q[VLW-2:0]];
`else
  logic unused_vm;
  assign unused_vm   = cmd_vm;
  assign elem_active = 1'b1;
`endif

  assign accept    = cmd_valid && cmd_ready;
  assign last_elem = (i_q + VLW'(1)) == vl_q;
  // Largest legal vl for the captured SEW is VLEN/SEW.
  assign vl_limit  = VLW'(MAX_VL) >> sew_q;
  assign cfg_bad   = (sew_q == SEW_ILL) || (vl_q > vl_limit);
  // Bit offset of element i inside the register: i * 8 * nbytes.
  assign boff      = BW'({i_q, 3'b000} << sew_q);
  assign ld_fire   = mem_valid && mem_ready && !store_q;

  always_comb begin
    st_elem = '0;
    case (sew_q)
      SEW_8:   st_elem[7:0]  = buf_q[boff +: 8];
      SEW_16:  st_elem[15:0] = buf_q[boff +: 16];
      SEW_32:  st_elem       = buf_q[boff +: 32];
      default: st_elem       = '0;
    endcase
  end

  vec_lsu_lane_align u_align (
    .sew        (sew_q),
    .lane       (ea_q[1:0]),
    .rdata      (mem_rdata),
    .st_elem    (st_elem),
    .ld_elem    (ld_elem),
    .st_wdata   (st_wdata),
    .st_wstrb   (st_wstrb),
    .misaligned (misaligned)
  );

  // NOTE: sequential state is written with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    cmd_ready = 1'b0;
    mem_valid = 1'b0;
    vreg_we   = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (cfg_bad || vl_q == '0) state_d = S_DONE;
        else                       state_d = S_REQ;
      end
      S_REQ: begin
        // Masked-off elements skip the bus entirely; misalignment aborts the whole command.
        if (!elem_active)   state_d = S_NEXT;
        else if (misaligned) state_d = S_DONE;
        else begin
          mem_valid = 1'b1;
          if (mem_ready) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (last_elem) state_d = store_q ? S_DONE : S_WB;
        else           state_d = S_REQ;
      end
      S_WB: begin
        vreg_we = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the element buffer is reset along with the control state because it drives
  // vreg_wdata directly and must read as zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_q  <= 1'b0;
      ea_q     <= '0;
      stride_q <= '0;
      vl_q     <= '0;
      i_q      <= '0;
      sew_q    <= SEW_8;
      vreg_q   <= '0;
      buf_q    <= '0;
      err_q    <= 1'b0;
`ifdef VEC_LSU_MASK_EN
      vm_q     <= 1'b1;
      mask_q   <= '0;
`endif
    end else begin
      if (accept) begin
        store_q  <= cmd_store;
        ea_q     <= cmd_base;
        stride_q <= cmd_stride;
        vl_q     <= cmd_vl;
        i_q      <= '0;
        sew_q    <= sew_e'(cmd_sew);
        vreg_q   <= cmd_vreg;
        buf_q    <= cmd_vdata;
        err_q    <= 1'b0;
`ifdef VEC_LSU_MASK_EN
        vm_q     <= cmd_vm;
        mask_q   <= cmd_mask;
`endif
      end
      if (state_q == S_CHECK) err_q <= cfg_bad;
      if (state_q == S_REQ && elem_active && misaligned) err_q <= 1'b1;
      if (ld_fire) begin
        case (sew_q)
          SEW_8:   buf_q[boff +: 8]  <= ld_elem[7:0];
          SEW_16:  buf_q[boff +: 16] <= ld_elem[15:0];
          SEW_32:  buf_q[boff +: 32] <= ld_elem;
          default: ;
        endcase
      end
      if (state_q == S_NEXT) begin
        i_q  <= i_q + VLW'(1);
        ea_q <= ea_q + stride_q;   // wraps modulo 2^32
      end
    end
  end

  // Bus fields are forced to zero outside a live request.
  assign mem_addr   = mem_valid ? {ea_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata  = (mem_valid && store_q) ? st_wdata : 32'h0;
  assign mem_wstrb  = (mem_valid && store_q) ? st_wstrb : 4'h0;
  assign vreg_waddr = vreg_q;
  assign vreg_wdata = buf_q;
  assign err        = err_q;

endmodule
